// File: rtl/hci_bank_starvation_scheduler.sv
// Per-bank TCDM arbitration between the high-priority log interconnect and
// the low-priority HWPE interconnect. Static priority resolves conflicts,
// and a programmable starvation limit temporarily hands a bounded burst to
// the losing side so it always makes progress.
module hci_bank_starvation_scheduler #(
  parameter int N_MEM     = 16,
  parameter int STALL_W   = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               invert_prio_i,
  input  logic [STALL_W-1:0] max_stall_i,
  input  logic [N_MEM-1:0]   req_high_i,
  input  logic [N_MEM-1:0]   req_low_i,
  output logic [N_MEM-1:0]   gnt_high_o,
  output logic [N_MEM-1:0]   gnt_low_o,
  output logic [N_MEM-1:0]   inverted_o,
  output logic [CNT_W-1:0]   inv_event_cnt_o
);

  localparam int BURST_W = $clog2(BURST_LEN + 1);
  localparam int POP_W   = $clog2(N_MEM + 1);

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_INVERTED = 1'b1
  } bankState_e;

  bankState_e         r_state    [N_MEM];
  logic [STALL_W-1:0] r_stallCnt [N_MEM];
  logic [BURST_W-1:0] r_burstCnt [N_MEM];
  logic               r_invPrio;
  logic [CNT_W-1:0]   r_eventCnt;

  bankState_e         w_stateNext [N_MEM];
  logic [STALL_W-1:0] w_stallNext [N_MEM];
  logic [BURST_W-1:0] w_burstNext [N_MEM];
  logic [N_MEM-1:0]   w_winReq;
  logic [N_MEM-1:0]   w_loseReq;
  logic [N_MEM-1:0]   w_invEff;
  logic [N_MEM-1:0]   w_gntWin;
  logic [N_MEM-1:0]   w_gntLose;
  logic [N_MEM-1:0]   w_enter;
  logic [POP_W-1:0]   w_enterCount;
  logic [CNT_W:0]     w_eventSum;
  logic [CNT_W-1:0]   w_eventNext;
  logic               w_flush;
  logic               w_prioChange;

  assign w_flush      = rst_i | clear_i;
  assign w_prioChange = invert_prio_i ^ r_invPrio;

  assign w_winReq  = invert_prio_i ? req_low_i  : req_high_i;
  assign w_loseReq = invert_prio_i ? req_high_i : req_low_i;

  // The loser only wins a conflict while its bank is effectively inverted;
  // a lone requester is always served.
  assign w_gntLose = w_loseReq & (~w_winReq | w_invEff);
  assign w_gntWin  = w_winReq & ~(w_loseReq & w_invEff);

  assign gnt_high_o = w_flush ? '0 : (invert_prio_i ? w_gntLose : w_gntWin);
  assign gnt_low_o  = w_flush ? '0 : (invert_prio_i ? w_gntWin  : w_gntLose);

  assign inv_event_cnt_o = r_eventCnt;

  // Per-bank next-state: stall accounting in NORMAL, burst accounting in
  // INVERTED; a priority flip ignores the inverted state and parks every bank.
  always_comb begin
    w_invEff   = '0;
    w_enter    = '0;
    inverted_o = '0;
    for (int b = 0; b < N_MEM; b++) begin
      w_stateNext[b] = r_state[b];
      w_stallNext[b] = r_stallCnt[b];
      w_burstNext[b] = r_burstCnt[b];
      inverted_o[b]  = (r_state[b] == ST_INVERTED);
      w_invEff[b]    = (r_state[b] == ST_INVERTED) && !w_prioChange;
      if (w_prioChange) begin
        w_stateNext[b] = ST_NORMAL;
        w_stallNext[b] = '0;
        w_burstNext[b] = '0;
      end else if (r_state[b] == ST_NORMAL) begin
        w_burstNext[b] = '0;
        if (w_winReq[b] && w_loseReq[b]) begin
          w_stallNext[b] = (r_stallCnt[b] == '1) ? '1 : r_stallCnt[b] + STALL_W'(1);
        end else begin
          w_stallNext[b] = '0;
        end
        if ((max_stall_i != '0) && (w_stallNext[b] >= max_stall_i)) begin
          w_stateNext[b] = ST_INVERTED;
          w_stallNext[b] = '0;
          w_burstNext[b] = '0;
          w_enter[b]     = 1'b1;
        end
      end else begin
        w_stallNext[b] = '0;
        if (!w_loseReq[b]) begin
          w_stateNext[b] = ST_NORMAL;
          w_burstNext[b] = '0;
        end else if ((r_burstCnt[b] + BURST_W'(1)) == BURST_W'(BURST_LEN)) begin
          w_stateNext[b] = ST_NORMAL;
          w_burstNext[b] = '0;
        end else begin
          w_burstNext[b] = r_burstCnt[b] + BURST_W'(1);
        end
      end
    end
  end

  // Count banks entering INVERTED this cycle and add them with saturation.
  always_comb begin
    w_enterCount = '0;
    for (int b = 0; b < N_MEM; b++) begin
      w_enterCount = w_enterCount + POP_W'(w_enter[b]);
    end
    w_eventSum  = {1'b0, r_eventCnt} + (CNT_W + 1)'(w_enterCount);
    w_eventNext = w_eventSum[CNT_W] ? '1 : w_eventSum[CNT_W-1:0];
  end

  // State registers; reset and soft clear both drop all per-bank progress.
  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      for (int b = 0; b < N_MEM; b++) begin
        r_state[b]    <= ST_NORMAL;
        r_stallCnt[b] <= '0;
        r_burstCnt[b] <= '0;
      end
      r_invPrio  <= invert_prio_i;
      r_eventCnt <= '0;
    end else begin
      for (int b = 0; b < N_MEM; b++) begin
        r_state[b]    <= w_stateNext[b];
        r_stallCnt[b] <= w_stallNext[b];
        r_burstCnt[b] <= w_burstNext[b];
      end
      r_invPrio  <= invert_prio_i;
      r_eventCnt <= w_eventNext;
    end
  end

endmodule

// File: tb/tb_hci_bank_starvation_scheduler.sv
// Scoreboard bench for hci_bank_starvation_scheduler: the driver pushes
// hand-computed expectations per cycle, the monitor pops and compares them
// mid-cycle. The event counter is narrowed so saturation is reachable.
module tb_hci_bank_starvation_scheduler;

  localparam int N_MEM     = 16;
  localparam int STALL_W   = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 6;
  localparam logic [15:0] ALL  = 16'hFFFF;
  localparam logic [15:0] NONE = 16'h0000;

  typedef struct {
    logic [15:0]      gntHigh;
    logic [15:0]      gntLow;
    logic [15:0]      inv;
    logic [CNT_W-1:0] cnt;
    bit               chkState;
  } expect_t;

  logic               clk;
  logic               rst;
  logic               clear;
  logic               invPrio;
  logic [STALL_W-1:0] maxStall;
  logic [N_MEM-1:0]   reqHigh;
  logic [N_MEM-1:0]   reqLow;
  logic [N_MEM-1:0]   gntHigh;
  logic [N_MEM-1:0]   gntLow;
  logic [N_MEM-1:0]   invertedOut;
  logic [CNT_W-1:0]   eventCnt;

  expect_t expQ[$];
  string   nameQ[$];
  int      compared   = 0;
  int      mismatched = 0;

  hci_bank_starvation_scheduler #(
    .N_MEM(N_MEM), .STALL_W(STALL_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clear_i(clear),
    .invert_prio_i(invPrio),
    .max_stall_i(maxStall),
    .req_high_i(reqHigh),
    .req_low_i(reqLow),
    .gnt_high_o(gntHigh),
    .gnt_low_o(gntLow),
    .inverted_o(invertedOut),
    .inv_event_cnt_o(eventCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue its expectation.
  task automatic applyStimulus(input string name, input logic r, input logic c,
                               input logic ip, input logic [STALL_W-1:0] ms,
                               input logic [15:0] rh, input logic [15:0] rl,
                               input logic [15:0] eh, input logic [15:0] el,
                               input logic [15:0] ei, input logic [CNT_W-1:0] ec,
                               input bit cs);
    expect_t e;
    @(posedge clk);
    #1;
    rst      = r;
    clear    = c;
    invPrio  = ip;
    maxStall = ms;
    reqHigh  = rh;
    reqLow   = rl;
    e.gntHigh  = eh;
    e.gntLow   = el;
    e.inv      = ei;
    e.cnt      = ec;
    e.chkState = cs;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h at %0t", name, field, act, exp, $time);
    end
  endtask

  // Monitor: every mid-cycle, compare the DUT against the oldest expectation.
  initial begin
    expect_t e;
    string   n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, "gntHigh", 32'(gntHigh), 32'(e.gntHigh));
        checkOutput(n, "gntLow", 32'(gntLow), 32'(e.gntLow));
        if (e.chkState) begin
          checkOutput(n, "inverted", 32'(invertedOut), 32'(e.inv));
          checkOutput(n, "eventCnt", 32'(eventCnt), 32'(e.cnt));
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int waitCycles;
    rst = 1'b1; clear = 1'b0; invPrio = 1'b0; maxStall = '0;
    reqHigh = ALL; reqLow = ALL;

    // Reset with every request high: no grants, state cleared.
    applyStimulus("reset0", 1, 0, 0, 8'd0, ALL, ALL, NONE, NONE, NONE, 6'd0, 0);
    applyStimulus("reset1", 1, 0, 0, 8'd0, ALL, ALL, NONE, NONE, NONE, 6'd0, 1);
    applyStimulus("afterReset", 0, 0, 0, 8'd0, ALL, ALL, ALL, NONE, NONE, 6'd0, 1);
    applyStimulus("idleA", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd0, 1);

    // Starvation on bank 0 with limit 3 and burst 4.
    for (int i = 0; i < 3; i++)
      applyStimulus("starveHigh", 0, 0, 0, 8'd3, 16'h0001, 16'h0001, 16'h0001, NONE, NONE, 6'd0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus("starveBurst", 0, 0, 0, 8'd3, 16'h0001, 16'h0001, NONE, 16'h0001, 16'h0001, 6'd1, 1);
    applyStimulus("starveBack", 0, 0, 0, 8'd3, 16'h0001, 16'h0001, 16'h0001, NONE, NONE, 6'd1, 1);
    applyStimulus("idleB", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd1, 1);

    // Early exit on bank 2: low request drops after one burst grant.
    for (int i = 0; i < 3; i++)
      applyStimulus("earlyHigh", 0, 0, 0, 8'd3, 16'h0004, 16'h0004, 16'h0004, NONE, NONE, 6'd1, 1);
    applyStimulus("earlyInv", 0, 0, 0, 8'd3, 16'h0004, 16'h0004, NONE, 16'h0004, 16'h0004, 6'd2, 1);
    applyStimulus("earlyDrop", 0, 0, 0, 8'd3, 16'h0004, NONE, 16'h0004, NONE, 16'h0004, 6'd2, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("earlyRestart", 0, 0, 0, 8'd3, 16'h0004, 16'h0004, 16'h0004, NONE, NONE, 6'd2, 1);
    applyStimulus("earlyReinv", 0, 0, 0, 8'd3, 16'h0004, 16'h0004, NONE, 16'h0004, 16'h0004, 6'd3, 1);
    applyStimulus("idleC0", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, 16'h0004, 6'd3, 1);
    applyStimulus("idleC1", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd3, 1);

    // Limit disabled: pure static priority for 100 cycles.
    for (int i = 0; i < 100; i++)
      applyStimulus("disabled", 0, 0, 0, 8'd0, ALL, ALL, ALL, NONE, NONE, 6'd3, 1);
    applyStimulus("idleD", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd3, 1);

    // Priority swap while bank 1 is inverted, then a fresh full burst.
    for (int i = 0; i < 3; i++)
      applyStimulus("swapHigh", 0, 0, 0, 8'd3, 16'h0002, 16'h0002, 16'h0002, NONE, NONE, 6'd3, 1);
    applyStimulus("swapInv", 0, 0, 0, 8'd3, 16'h0002, 16'h0002, NONE, 16'h0002, 16'h0002, 6'd4, 1);
    applyStimulus("swapEdge", 0, 0, 1, 8'd3, 16'h0002, 16'h0002, NONE, 16'h0002, 16'h0002, 6'd4, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("swapLowWins", 0, 0, 1, 8'd3, 16'h0002, 16'h0002, NONE, 16'h0002, NONE, 6'd4, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus("swapBurst", 0, 0, 1, 8'd3, 16'h0002, 16'h0002, 16'h0002, NONE, 16'h0002, 6'd5, 1);
    applyStimulus("swapBack", 0, 0, 1, 8'd3, 16'h0002, 16'h0002, NONE, 16'h0002, NONE, 6'd5, 1);
    applyStimulus("idleE0", 0, 0, 1, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd5, 1);
    applyStimulus("idleE1", 0, 0, 0, 8'd3, NONE, NONE, NONE, NONE, NONE, 6'd5, 1);

    // Soft clear, then all 16 banks trip together until the counter saturates.
    applyStimulus("clear", 0, 1, 0, 8'd1, ALL, ALL, NONE, NONE, NONE, 6'd5, 0);
    applyStimulus("afterClear", 0, 0, 0, 8'd1, NONE, NONE, NONE, NONE, NONE, 6'd0, 1);
    applyStimulus("allEnter1", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd0, 1);
    applyStimulus("allInv1", 0, 0, 0, 8'd1, ALL, ALL, NONE, ALL, ALL, 6'd16, 1);
    applyStimulus("allDrop1", 0, 0, 0, 8'd1, ALL, NONE, ALL, NONE, ALL, 6'd16, 1);
    applyStimulus("allEnter2", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd16, 1);
    applyStimulus("allInv2", 0, 0, 0, 8'd1, ALL, ALL, NONE, ALL, ALL, 6'd32, 1);
    applyStimulus("allDrop2", 0, 0, 0, 8'd1, ALL, NONE, ALL, NONE, ALL, 6'd32, 1);
    applyStimulus("allEnter3", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd32, 1);
    applyStimulus("allInv3", 0, 0, 0, 8'd1, ALL, ALL, NONE, ALL, ALL, 6'd48, 1);
    applyStimulus("allDrop3", 0, 0, 0, 8'd1, ALL, NONE, ALL, NONE, ALL, 6'd48, 1);
    applyStimulus("allEnter4", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd48, 1);
    applyStimulus("allSat4", 0, 0, 0, 8'd1, ALL, ALL, NONE, ALL, ALL, 6'd63, 1);
    applyStimulus("allDrop4", 0, 0, 0, 8'd1, ALL, NONE, ALL, NONE, ALL, 6'd63, 1);
    applyStimulus("allEnter5", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd63, 1);
    applyStimulus("allSat5", 0, 0, 0, 8'd1, ALL, ALL, NONE, ALL, ALL, 6'd63, 1);

    // Reset in the middle of a burst drops it completely.
    applyStimulus("midBurstRst", 1, 0, 0, 8'd1, ALL, ALL, NONE, NONE, ALL, 6'd63, 1);
    applyStimulus("afterMidRst", 0, 0, 0, 8'd1, ALL, ALL, ALL, NONE, NONE, 6'd0, 1);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
